// File: rtl/borrow_lookahead_subtractor_seq.sv
// Multi-cycle subtractor: diff = x - y - bin, one 4-bit borrow-lookahead slice per clock, LSB first.
// Optional macro SUB_SIGNED_OVF_EN adds a two's-complement overflow output (ovf).
//
// state | meaning
// IDLE  | waiting for start; ready=1
// RUN   | one slice computed per edge; busy=1
// DONE  | result valid for one cycle; ready=1, done=1

module borrow_lookahead_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("borrow_lookahead_subtractor_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic             b;
  logic [KW-1:0]    k;
  logic             accept;
  logic             last_slice;

  logic [KW+1:0]    sh;
  logic [3:0]       xs;
  logic [3:0]       ys;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [4:0]       bc;
  logic [3:0]       d;

  assign accept     = start && ready;
  assign last_slice = (k == KLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current slice operands; borrows are flattened sums of products, no ripple.
  always_comb begin
    sh    = {k, 2'b00};
    xs    = 4'(xr >> sh);
    ys    = 4'(yr >> sh);
    g     = ~xs & ys;
    p     = ~(xs ^ ys);
    bc[0] = b;
    bc[1] = g[0] | (p[0] & b);
    bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & b);
    bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & b);
    bc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & b);
    d     = xs ^ ys ^ bc[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr   <= '0;
      yr   <= '0;
      b    <= 1'b0;
      k    <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      xr   <= x;
      yr   <= y;
      b    <= bin;
      k    <= '0;
      diff <= '0;
    end else if (state == RUN) begin
      // diff was cleared at accept, so OR-ing in the slice leaves upper bits at 0.
      diff <= diff | (WIDTH'(d) << sh);
      b    <= bc[4];
      k    <= k + 1'b1;
      if (last_slice) begin
        bout <= bc[4];
`ifdef SUB_SIGNED_OVF_EN
        ovf  <= bc[3] ^ bc[4];
`endif
      end
    end
  end

endmodule
